// File: rtl/uart_tx_datapath.sv
// Purpose: UART transmit datapath - data register, shift register, shift counter, baud tick.
// Latency: load/start/shift/clear act on the next clk edge; serial_out and bit_tick are registered.
// Backpressure: none; the controller paces shift with bit_tick and stops on bc_lt_bcmax.
module uart_tx_datapath #(
    parameter int WORD_SIZE    = 8,
    parameter int BC_WIDTH     = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int BAUD_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [WORD_SIZE-1:0] data_bus,
    input  logic                 load_xmt_datareg,
    input  logic                 load_xmt_shiftreg,
    input  logic                 start,
    input  logic                 shift,
    input  logic                 clear,
    output logic                 serial_out,
    output logic                 bc_lt_bcmax,
    output logic                 bit_tick
);

    // Count value once the stop bit is on the line; the counter saturates here.
    localparam logic [BC_WIDTH-1:0]   BC_MAX    = BC_WIDTH'(WORD_SIZE + 1);
    localparam logic [BAUD_WIDTH-1:0] BAUD_LAST = BAUD_WIDTH'(CLKS_PER_BIT - 1);

    logic [WORD_SIZE-1:0]  data_reg;
    logic [WORD_SIZE:0]    shft_reg;
    logic [BC_WIDTH-1:0]   bit_count;
    logic [BAUD_WIDTH-1:0] baud_cnt;
    logic                  busy;

    logic [WORD_SIZE:0]    shft_nxt;
    logic [BC_WIDTH-1:0]   bc_nxt;
    logic [BAUD_WIDTH-1:0] baud_nxt;
    logic                  busy_nxt;

    // Next-state for the frame: clear beats start beats shift beats shift-register load.
    always_comb begin
        shft_nxt = shft_reg;
        bc_nxt   = bit_count;
        busy_nxt = busy;
        baud_nxt = baud_cnt;
        if (busy) begin
            baud_nxt = (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + 1'b1;
        end
        if (clear) begin
            bc_nxt   = '0;
            shft_nxt = '1;
            busy_nxt = 1'b0;
            baud_nxt = '0;
        end else if (start) begin
            shft_nxt[0] = 1'b0;
            busy_nxt    = 1'b1;
            baud_nxt    = '0;
        end else if (shift) begin
            // Ones shift in from the top so the line rests high after the stop bit.
            shft_nxt = {1'b1, shft_reg[WORD_SIZE:1]};
            if (bit_count != BC_MAX) begin
                bc_nxt = bit_count + 1'b1;
            end
            // Stop bit now on the line: the frame is done, so stop the baud timer.
            if (bc_nxt == BC_MAX) begin
                busy_nxt = 1'b0;
                baud_nxt = '0;
            end
        end else if (load_xmt_shiftreg) begin
            shft_nxt = {data_reg, 1'b1};
        end
    end

    // Data register loads independently so the next byte can be staged mid-frame.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_reg <= '0;
        end else if (load_xmt_datareg) begin
            data_reg <= data_bus;
        end
    end

    // Frame state plus a registered tick that is high while baud_cnt sits on its last count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shft_reg  <= '1;
            bit_count <= '0;
            baud_cnt  <= '0;
            busy      <= 1'b0;
            bit_tick  <= 1'b0;
        end else begin
            shft_reg  <= shft_nxt;
            bit_count <= bc_nxt;
            baud_cnt  <= baud_nxt;
            busy      <= busy_nxt;
            bit_tick  <= busy_nxt && (baud_nxt == BAUD_LAST);
        end
    end

    assign serial_out  = shft_reg[0];
    assign bc_lt_bcmax = (bit_count < BC_MAX);

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath with a 4-clock bit period.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge before driving.
// Each frame bit is checked on every clock of its bit period along with the tick pattern.
module tb_uart_tx_datapath;

    logic       clk;
    logic       rst_b;
    logic [7:0] data_bus;
    logic       load_xmt_datareg;
    logic       load_xmt_shiftreg;
    logic       start;
    logic       shift;
    logic       clear;
    logic       serial_out;
    logic       bc_lt_bcmax;
    logic       bit_tick;

    int pass_cnt;
    int total_cnt;
    int n_ticks;

    uart_tx_datapath #(
        .WORD_SIZE   (8),
        .BC_WIDTH    (4),
        .CLKS_PER_BIT(4),
        .BAUD_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .data_bus         (data_bus),
        .load_xmt_datareg (load_xmt_datareg),
        .load_xmt_shiftreg(load_xmt_shiftreg),
        .start            (start),
        .shift            (shift),
        .clear            (clear),
        .serial_out       (serial_out),
        .bc_lt_bcmax      (bc_lt_bcmax),
        .bit_tick         (bit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: rising edge, then back to the falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count ticks over n cycles while no controls are applied.
    task automatic count_ticks(input int n);
        n_ticks = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (bit_tick === 1'b1) n_ticks = n_ticks + 1;
        end
    endtask

    // Present frame bits first..last; each lasts 4 clocks, tick expected on the 4th,
    // and shift is applied on that tick. inj selects a bit during which 0xFF is
    // loaded into the data register (-1 for none).
    task automatic run_bits(input logic [9:0] fb, input int first, input int last, input int inj);
        for (int i = first; i <= last; i++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("line bit%0d c%0d", i, c), serial_out, fb[i]);
                check($sformatf("tick bit%0d c%0d", i, c), bit_tick, (c == 3));
                check($sformatf("bclt bit%0d c%0d", i, c), bc_lt_bcmax, 1'b1);
                load_xmt_datareg = (i == inj) && (c == 1);
                if ((i == inj) && (c == 1)) data_bus = 8'hFF;
                shift = (c == 3);
                step();
            end
        end
        shift            = 1'b0;
        load_xmt_datareg = 1'b0;
    endtask

    // Load a byte into the data register, copy it to the shift register, then start.
    task automatic begin_frame(input logic [7:0] d);
        data_bus         = d;
        load_xmt_datareg = 1'b1;
        step();
        load_xmt_datareg  = 1'b0;
        load_xmt_shiftreg = 1'b1;
        step();
        load_xmt_shiftreg = 1'b0;
        check("line idle after shiftreg load", serial_out, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        pass_cnt          = 0;
        total_cnt         = 0;
        n_ticks           = 0;
        rst_b             = 1'b1;
        data_bus          = 8'h00;
        load_xmt_datareg  = 1'b0;
        load_xmt_shiftreg = 1'b0;
        start             = 1'b0;
        shift             = 1'b0;
        clear             = 1'b0;

        // Reset asserted mid-clock: outputs settle before the next edge.
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        check("reset serial_out", serial_out, 1'b1);
        check("reset bc_lt_bcmax", bc_lt_bcmax, 1'b1);
        check("reset bit_tick", bit_tick, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        step();
        check("idle serial_out", serial_out, 1'b1);

        // Frame 0xA5: 0,1,0,1,0,0,1,0,1 then stop 1.
        begin_frame(8'hA5);
        run_bits({1'b1, 8'hA5, 1'b0}, 0, 8, -1);
        check("A5 stop bit", serial_out, 1'b1);
        check("A5 bc_lt_bcmax low", bc_lt_bcmax, 1'b0);
        count_ticks(12);
        check_int("A5 ticks after frame", n_ticks, 0);
        check("A5 line after frame", serial_out, 1'b1);
        pulse_clear();
        check("clear bc_lt_bcmax", bc_lt_bcmax, 1'b1);

        // Abort 0x3C after three shifts.
        begin_frame(8'h3C);
        run_bits({1'b1, 8'h3C, 1'b0}, 0, 2, -1);
        check("3C d2 on line", serial_out, 1'b1);
        pulse_clear();
        check("abort serial_out", serial_out, 1'b1);
        check("abort bc_lt_bcmax", bc_lt_bcmax, 1'b1);
        count_ticks(10);
        check_int("abort ticks", n_ticks, 0);

        // Priority: clear+shift, start+shift, then saturation of the counter.
        begin_frame(8'hFF);
        check("FF start bit", serial_out, 1'b0);
        for (int k = 0; k < 3; k++) begin
            shift = 1'b1;
            step();
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear+shift line", serial_out, 1'b1);
        check("clear+shift bclt", bc_lt_bcmax, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("start+shift line", serial_out, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("shift%0d line", k), serial_out, 1'b1);
            check($sformatf("shift%0d bclt", k), bc_lt_bcmax, 1'b1);
        end
        step();
        check("shift9 bclt", bc_lt_bcmax, 1'b0);
        check("shift9 line", serial_out, 1'b1);
        for (int k = 10; k <= 17; k++) begin
            step();
            check($sformatf("sat shift%0d bclt", k), bc_lt_bcmax, 1'b0);
            check($sformatf("sat shift%0d line", k), serial_out, 1'b1);
        end
        shift = 1'b0;
        pulse_clear();

        // Data register loaded with 0xFF mid-frame must not disturb the 0x00 frame.
        begin_frame(8'h00);
        run_bits({1'b1, 8'h00, 1'b0}, 0, 8, 2);
        check("00 stop bit", serial_out, 1'b1);
        check("00 bc_lt_bcmax low", bc_lt_bcmax, 1'b0);
        pulse_clear();
        load_xmt_shiftreg = 1'b1;
        step();
        load_xmt_shiftreg = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_bits({1'b1, 8'hFF, 1'b0}, 0, 0, -1);
        check("staged FF d0", serial_out, 1'b1);
        pulse_clear();

        // Reset pulse mid-frame: line high at once, frame does not resume.
        begin_frame(8'h00);
        run_bits({1'b1, 8'h00, 1'b0}, 0, 1, -1);
        check("pre-reset line low", serial_out, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        check("midframe reset line", serial_out, 1'b1);
        check("midframe reset tick", bit_tick, 1'b0);
        check("midframe reset bclt", bc_lt_bcmax, 1'b1);
        @(negedge clk);
        rst_b = 1'b1;
        n_ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bit_tick === 1'b1 || serial_out !== 1'b1) n_ticks = n_ticks + 1;
        end
        check_int("no resume after reset", n_ticks, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
